// File: rtl/claa_seq.sv
// claa_seq: sequential adder/subtractor that time-shares one carry-lookahead slice across all operand words

// claa: WORD_WIDTH-bit carry-lookahead adder; each carry is built directly from generate/propagate terms
module claa #(
    parameter int W = 8
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         ci,
    output logic [W-1:0] s,
    output logic         co
);
    logic [W-1:0] p;
    logic [W-1:0] g;
    logic [W:0]   c;
    logic         pp;

    // Flat lookahead: carry i+1 = g[i] | p[i]g[i-1] | ... | p[i..0]ci, no ripple chain through c
    always_comb begin
        p = a ^ b;
        g = a & b;
        c = '0;
        pp = 1'b0;
        c[0] = ci;
        for (int i = 0; i < W; i++) begin
            c[i+1] = g[i];
            pp = p[i];
            for (int j = i - 1; j >= 0; j--) begin
                c[i+1] = c[i+1] | (g[j] & pp);
                pp = pp & p[j];
            end
            c[i+1] = c[i+1] | (ci & pp);
        end
        s = p ^ c[W-1:0];
        co = c[W];
    end
endmodule

module claa_seq #(
    parameter int WORD_WIDTH = 8,
    parameter int WORD_COUNT = 4
) (
    input  logic                             clk_i,
    input  logic                             rst_i,
    input  logic                             valid_i,
    output logic                             ready_o,
    input  logic [WORD_WIDTH*WORD_COUNT-1:0] a_i,
    input  logic [WORD_WIDTH*WORD_COUNT-1:0] b_i,
    input  logic                             sub_i,
    input  logic                             c_i,
    output logic                             valid_o,
    input  logic                             ready_i,
    output logic [WORD_WIDTH*WORD_COUNT-1:0] r_o,
    output logic                             c_o,
    output logic                             v_o,
    output logic                             busy_o
);
    localparam int N  = WORD_WIDTH * WORD_COUNT;
    localparam int CW = WORD_COUNT > 1 ? $clog2(WORD_COUNT) : 1;
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]            state;
    logic [N-1:0]          a_q;
    logic [N-1:0]          b_q;
    logic                  carry;
    logic [CW-1:0]         k;
    logic [WORD_WIDTH-1:0] a_s;
    logic [WORD_WIDTH-1:0] b_s;
    logic [WORD_WIDTH-1:0] sum;
    logic                  cout;
    logic                  last;

    assign ready_o = state == IDLE;
    assign valid_o = state == DONE;
    assign busy_o  = state == RUN;
    assign last    = k == CW'(WORD_COUNT - 1);

    // Select the current slice of each latched operand for the shared adder
    always_comb begin
        a_s = '0;
        b_s = '0;
        for (int j = 0; j < WORD_COUNT; j++) begin
            if (k == CW'(j)) begin
                a_s = a_q[j*WORD_WIDTH +: WORD_WIDTH];
                b_s = b_q[j*WORD_WIDTH +: WORD_WIDTH];
            end
        end
    end

    claa #(.W(WORD_WIDTH)) u_claa (
        .a  (a_s),
        .b  (b_s),
        .ci (carry),
        .s  (sum),
        .co (cout)
    );

    // Accept in IDLE, one slice per cycle in RUN, hold the result in DONE until the consumer takes it
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= IDLE;
            a_q   <= '0;
            b_q   <= '0;
            carry <= 1'b0;
            k     <= '0;
            r_o   <= '0;
            c_o   <= 1'b0;
            v_o   <= 1'b0;
        end else if (state == IDLE && valid_i) begin
            a_q   <= a_i;
            b_q   <= sub_i ? ~b_i : b_i;
            carry <= c_i ^ sub_i;
            k     <= '0;
            state <= RUN;
        end else if (state == RUN) begin
            carry <= cout;
            for (int j = 0; j < WORD_COUNT; j++) begin
                if (k == CW'(j)) r_o[j*WORD_WIDTH +: WORD_WIDTH] <= sum;
            end
            if (last) begin
                c_o   <= cout;
                v_o   <= a_q[N-1] ^ b_q[N-1] ^ sum[WORD_WIDTH-1] ^ cout;
                k     <= '0;
                state <= DONE;
            end else begin
                k <= k + 1'b1;
            end
        end else if (state == DONE && ready_i) begin
            state <= IDLE;
        end
    end
endmodule

// File: tb/tb_claa_seq.sv
// tb_claa_seq: directed and random checks of the sequential carry-lookahead adder
module tb_claa_seq;
    localparam int WW = 4;
    localparam int WC = 4;
    localparam int N  = WW * WC;

    logic         clk = 1'b0;
    logic         rst_i = 1'b0;
    logic         valid_i = 1'b0;
    logic         ready_o;
    logic [N-1:0] a_i = '0;
    logic [N-1:0] b_i = '0;
    logic         sub_i = 1'b0;
    logic         c_i = 1'b0;
    logic         valid_o;
    logic         ready_i = 1'b0;
    logic [N-1:0] r_o;
    logic         c_o;
    logic         v_o;
    logic         busy_o;

    int checks = 0;
    int errors = 0;

    claa_seq #(.WORD_WIDTH(WW), .WORD_COUNT(WC)) dut (
        .clk_i   (clk),
        .rst_i   (rst_i),
        .valid_i (valid_i),
        .ready_o (ready_o),
        .a_i     (a_i),
        .b_i     (b_i),
        .sub_i   (sub_i),
        .c_i     (c_i),
        .valid_o (valid_o),
        .ready_i (ready_i),
        .r_o     (r_o),
        .c_o     (c_o),
        .v_o     (v_o),
        .busy_o  (busy_o)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present a request for one edge and count edges until valid_o (bounded)
    task automatic start_wait(input logic [N-1:0] a, input logic [N-1:0] b, input logic sub, input logic c,
                              output int lat);
        a_i = a;
        b_i = b;
        sub_i = sub;
        c_i = c;
        valid_i = 1'b1;
        step();
        valid_i = 1'b0;
        lat = 0;
        while (!valid_o && lat < 20) begin
            step();
            lat++;
        end
        if (!valid_o) begin
            errors++;
            $display("FAIL timeout: valid_o never rose for a=%h b=%h", a, b);
        end
    endtask

    task automatic handshake(input int delay);
        repeat (delay) step();
        ready_i = 1'b1;
        step();
        ready_i = 1'b0;
    endtask

    task automatic model(input logic [N-1:0] a, input logic [N-1:0] b, input logic sub, input logic c,
                         output logic [N-1:0] r, output logic co, output logic vo);
        logic [N-1:0] bb;
        logic [N:0]   full;
        bb = sub ? ~b : b;
        full = {1'b0, a} + {1'b0, bb} + {{N{1'b0}}, c ^ sub};
        r = full[N-1:0];
        co = full[N];
        vo = (a[N-1] == bb[N-1]) && (r[N-1] != a[N-1]);
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        step();
        step();
        rst_i = 1'b0;
        checks++;
        if ({ready_o, valid_o, busy_o, c_o, v_o} !== 5'b10000 || r_o !== '0) begin
            errors++;
            $display("FAIL reset: rdy=%b vld=%b busy=%b r=%h c=%b v=%b, want 1 0 0 0000 0 0",
                     ready_o, valid_o, busy_o, r_o, c_o, v_o);
        end
    endtask

    task automatic test_add();
        int lat;
        start_wait(16'h00FF, 16'h0001, 1'b0, 1'b0, lat);
        checks++;
        if (lat != 4) begin
            errors++;
            $display("FAIL add_latency: got %0d edges, want 4", lat);
        end
        checks++;
        if ({r_o, c_o, v_o} !== {16'h0100, 2'b00}) begin
            errors++;
            $display("FAIL add_00ff: r=%h c=%b v=%b, want 0100 0 0", r_o, c_o, v_o);
        end
        handshake(0);
    endtask

    task automatic test_overflow();
        int lat;
        start_wait(16'hFFFF, 16'h0001, 1'b0, 1'b0, lat);
        checks++;
        if ({r_o, c_o, v_o} !== {16'h0000, 2'b10}) begin
            errors++;
            $display("FAIL add_ffff: r=%h c=%b v=%b, want 0000 1 0", r_o, c_o, v_o);
        end
        handshake(0);
        start_wait(16'h7FFF, 16'h0001, 1'b0, 1'b0, lat);
        checks++;
        if ({r_o, c_o, v_o} !== {16'h8000, 2'b01}) begin
            errors++;
            $display("FAIL add_7fff: r=%h c=%b v=%b, want 8000 0 1", r_o, c_o, v_o);
        end
        handshake(1);
    endtask

    task automatic test_sub();
        int lat;
        start_wait(16'h0005, 16'h0007, 1'b1, 1'b0, lat);
        checks++;
        if ({r_o, c_o, v_o} !== {16'hFFFE, 2'b00}) begin
            errors++;
            $display("FAIL sub_5_7: r=%h c=%b v=%b, want fffe 0 0", r_o, c_o, v_o);
        end
        handshake(0);
        start_wait(16'h0007, 16'h0005, 1'b1, 1'b0, lat);
        checks++;
        if ({r_o, c_o, v_o} !== {16'h0002, 2'b10}) begin
            errors++;
            $display("FAIL sub_7_5: r=%h c=%b v=%b, want 0002 1 0", r_o, c_o, v_o);
        end
        handshake(0);
        start_wait(16'h1000, 16'h0001, 1'b0, 1'b1, lat);
        checks++;
        if ({r_o, c_o, v_o} !== {16'h1002, 2'b00}) begin
            errors++;
            $display("FAIL add_cin: r=%h c=%b v=%b, want 1002 0 0", r_o, c_o, v_o);
        end
        handshake(0);
        start_wait(16'h8000, 16'h0001, 1'b1, 1'b0, lat);
        checks++;
        if ({r_o, c_o, v_o} !== {16'h7FFF, 2'b11}) begin
            errors++;
            $display("FAIL sub_ovf: r=%h c=%b v=%b, want 7fff 1 1", r_o, c_o, v_o);
        end
        handshake(0);
    endtask

    task automatic test_hold();
        int lat;
        start_wait(16'h1234, 16'h4321, 1'b0, 1'b0, lat);
        a_i = 16'hAAAA;
        b_i = 16'h5555;
        sub_i = 1'b1;
        valid_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if ({valid_o, ready_o, busy_o, r_o, c_o, v_o} !== {3'b100, 16'h5555, 2'b00}) begin
                errors++;
                $display("FAIL hold_%0d: vld=%b rdy=%b busy=%b r=%h c=%b v=%b, want 1 0 0 5555 0 0",
                         i, valid_o, ready_o, busy_o, r_o, c_o, v_o);
            end
        end
        ready_i = 1'b1;
        step();
        ready_i = 1'b0;
        checks++;
        if ({ready_o, valid_o, busy_o} !== 3'b100) begin
            errors++;
            $display("FAIL bubble: rdy=%b vld=%b busy=%b, want 1 0 0", ready_o, valid_o, busy_o);
        end
        step();
        valid_i = 1'b0;
        checks++;
        if (busy_o !== 1'b1) begin
            errors++;
            $display("FAIL accept_after_bubble: busy=%b, want 1", busy_o);
        end
        lat = 0;
        while (!valid_o && lat < 20) begin
            step();
            lat++;
        end
        checks++;
        if ({valid_o, r_o, c_o} !== {1'b1, 16'h5555, 1'b1}) begin
            errors++;
            $display("FAIL held_operand_sub: vld=%b r=%h c=%b, want 1 5555 1", valid_o, r_o, c_o);
        end
        handshake(0);
    endtask

    task automatic test_reset_mid();
        int lat;
        a_i = 16'h1234;
        b_i = 16'h1111;
        sub_i = 1'b0;
        c_i = 1'b0;
        valid_i = 1'b1;
        step();
        valid_i = 1'b0;
        step();
        step();
        rst_i = 1'b1;
        step();
        rst_i = 1'b0;
        checks++;
        if ({ready_o, valid_o, busy_o, c_o, v_o} !== 5'b10000 || r_o !== '0) begin
            errors++;
            $display("FAIL reset_mid: rdy=%b vld=%b busy=%b r=%h c=%b v=%b, want 1 0 0 0000 0 0",
                     ready_o, valid_o, busy_o, r_o, c_o, v_o);
        end
        lat = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (valid_o) lat++;
        end
        checks++;
        if (lat != 0) begin
            errors++;
            $display("FAIL reset_no_valid: valid_o high %0d cycles, want 0", lat);
        end
        start_wait(16'h1234, 16'h1111, 1'b0, 1'b0, lat);
        checks++;
        if ({r_o, c_o} !== {16'h2345, 1'b0}) begin
            errors++;
            $display("FAIL after_reset: r=%h c=%b, want 2345 0", r_o, c_o);
        end
        handshake(0);
    endtask

    task automatic test_random();
        logic [N-1:0] a;
        logic [N-1:0] b;
        logic         sub;
        logic         c;
        logic [N-1:0] er;
        logic         ec;
        logic         ev;
        int           lat;
        for (int i = 0; i < 1000; i++) begin
            a = N'($urandom);
            b = N'($urandom);
            sub = 1'($urandom);
            c = 1'($urandom);
            model(a, b, sub, c, er, ec, ev);
            start_wait(a, b, sub, c, lat);
            checks++;
            if ({r_o, c_o, v_o} !== {er, ec, ev}) begin
                errors++;
                $display("FAIL rand_%0d: a=%h b=%h sub=%b c=%b got r=%h c=%b v=%b, want %h %b %b",
                         i, a, b, sub, c, r_o, c_o, v_o, er, ec, ev);
            end
            handshake(int'($urandom_range(0, 3)));
        end
    endtask

    initial begin
        step();
        test_reset();
        test_add();
        test_overflow();
        test_sub();
        test_hold();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
